regfile_wr_arbiter: RTL and testbench



---
 rtl/regfile_wr_arbiter_pkg.sv | 17 +
 rtl/regfile_scoreboard.sv | 71 +++++++
 rtl/regfile_wr_arbiter.sv | 92 +++++++++
 tb/tb_regfile_wr_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wr_arbiter_pkg.sv
// regfile_wr_arbiter_pkg
//   Shared constants for the register-file write arbiter and its scoreboard:
//   default address/data widths, the hardwired-zero register index and the
//   requester indices used for the round-robin priority bit.
package regfile_wr_arbiter_pkg;

    localparam int unsigned AW_DEF   = 5;
    localparam int unsigned DW_DEF   = 32;

    // Register 0 reads as zero; writes and reservations to it are discarded.
    localparam int unsigned REG_ZERO = 0;

    // Requester indices, also the encoding of the priority bit.
    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_MDU = 1'b1;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Busy-bit scoreboard for outstanding register writes.
//   Ports:
//     clk, rst_n          clock, synchronous active-low reset
//     clr_valid/clr_addr  write granted this cycle; clears busy[clr_addr] at next posedge
//     rsv_valid/rsv_addr  issue stage reserves a destination register
//     rsv_stall           reservation refused (register still pending)
//     q_addr1/q_busy1     query port A (current busy bits, no grant bypass)
//     q_addr2/q_busy2     query port B
//     any_busy            at least one busy bit is set
module regfile_scoreboard
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int unsigned AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_valid,
    input  logic [AW-1:0] clr_addr,
    input  logic          rsv_valid,
    input  logic [AW-1:0] rsv_addr,
    output logic          rsv_stall,
    input  logic [AW-1:0] q_addr1,
    output logic          q_busy1,
    input  logic [AW-1:0] q_addr2,
    output logic          q_busy2,
    output logic          any_busy
);

    localparam int unsigned NREG = 1 << AW;

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    logic            clr_hits_rsv;
    logic            rsv_zero;
    logic            clr_zero;

    assign rsv_zero     = (rsv_addr == AW'(REG_ZERO));
    assign clr_zero     = (clr_addr == AW'(REG_ZERO));
    // A grant to the same register retires the pending write this cycle,
    // so the new reservation can proceed without waiting.
    assign clr_hits_rsv = clr_valid && (clr_addr == rsv_addr);

    // busy[0] is never set, so reservations of r0 never stall.
    assign rsv_stall = rsv_valid && busy[rsv_addr] && !clr_hits_rsv;

    assign q_busy1  = busy[q_addr1];
    assign q_busy2  = busy[q_addr2];
    assign any_busy = |busy;

    always_comb begin
        busy_next = busy;
        if (clr_valid && !clr_zero) begin
            busy_next[clr_addr] = 1'b0;
        end
        // Applied after the clear so a same-cycle set of the same register wins.
        if (rsv_valid && !rsv_stall && !rsv_zero) begin
            busy_next[rsv_addr] = 1'b1;
        end
        busy_next[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
//   Shares the single register-file write port between the ALU writeback
//   (requester 0) and the multi-cycle unit (requester 1) with round-robin
//   priority on contention, and tracks pending destinations in a scoreboard.
//   Ports:
//     clk, rst_n                       clock, synchronous active-low reset
//     req0_valid/ready/addr/data       ALU writeback request channel
//     req1_valid/ready/addr/data       mul/div/load writeback request channel
//     rsv_valid/rsv_addr/rsv_stall     issue-stage destination reservation
//     q_addr1/q_busy1, q_addr2/q_busy2 scoreboard operand queries
//     we/waddr/wdata                   registered register-file write port
//     idle                             nothing pending and no write in flight
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    input  logic          rsv_valid,
    input  logic [AW-1:0] rsv_addr,
    output logic          rsv_stall,
    input  logic [AW-1:0] q_addr1,
    output logic          q_busy1,
    input  logic [AW-1:0] q_addr2,
    output logic          q_busy2,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    output logic          idle
);

    logic          prio;
    logic          grant;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_data;
    logic          any_busy;

    assign req0_ready = req0_valid && (!req1_valid || prio == REQ_ALU);
    assign req1_ready = req1_valid && (!req0_valid || prio == REQ_MDU);
    assign grant      = req0_ready || req1_ready;
    assign g_addr     = req1_ready ? req1_addr : req0_addr;
    assign g_data     = req1_ready ? req1_data : req0_data;

    assign idle = !any_busy && !we;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio  <= REQ_ALU;
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            // On contention the winner holds prio, so handing it to the loser is a toggle.
            if (req0_valid && req1_valid) begin
                prio <= ~prio;
            end
            we <= grant && (g_addr != AW'(REG_ZERO));
            if (grant) begin
                waddr <= g_addr;
                wdata <= g_data;
            end
        end
    end

    regfile_scoreboard #(
        .AW(AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_valid (grant),
        .clr_addr  (g_addr),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rsv_stall (rsv_stall),
        .q_addr1   (q_addr1),
        .q_busy1   (q_busy1),
        .q_addr2   (q_addr2),
        .q_busy2   (q_busy2),
        .any_busy  (any_busy)
    );

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter
//   Directed bench for regfile_wr_arbiter: reset state, single writes,
//   round-robin contention, scoreboard reserve/commit/bypass, register 0
//   handling and reset during a grant.
module tb_regfile_wr_arbiter;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req0_ready;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_data;
    logic          req1_valid, req1_ready;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_data;
    logic          rsv_valid, rsv_stall;
    logic [AW-1:0] rsv_addr;
    logic [AW-1:0] q_addr1, q_addr2;
    logic          q_busy1, q_busy2;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          idle;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    regfile_wr_arbiter #(
        .AW(AW),
        .DW(DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .rsv_valid  (rsv_valid),
        .rsv_addr   (rsv_addr),
        .rsv_stall  (rsv_stall),
        .q_addr1    (q_addr1),
        .q_busy1    (q_busy1),
        .q_addr2    (q_addr2),
        .q_busy2    (q_busy2),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .idle       (idle)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        rsv_valid  = 1'b0; rsv_addr  = '0;
        q_addr1    = '0;   q_addr2   = '0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_we",     32'(we),         32'd0);
        chk("rst_waddr",  32'(waddr),      32'd0);
        chk("rst_wdata",  wdata,           32'd0);
        chk("rst_idle",   32'(idle),       32'd1);
        chk("rst_rdy0",   32'(req0_ready), 32'd0);
        chk("rst_rdy1",   32'(req1_ready), 32'd0);
        chk("rst_stall",  32'(rsv_stall),  32'd0);

        // 1: single requester
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'h1234_5678;
        #1;
        chk("t1_rdy0", 32'(req0_ready), 32'd1);
        chk("t1_rdy1", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        chk("t1_we",    32'(we),    32'd1);
        chk("t1_waddr", 32'(waddr), 32'd5);
        chk("t1_wdata", wdata,      32'h1234_5678);
        chk("t1_idle",  32'(idle),  32'd0);
        tick();
        chk("t1_we_off",   32'(we),    32'd0);
        chk("t1_waddr_hold", 32'(waddr), 32'd5);
        chk("t1_wdata_hold", wdata,      32'h1234_5678);
        chk("t1_idle_back",  32'(idle),  32'd1);

        // 2: contention alternates 0,1,0,1 starting from prio 0
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'hAAAA_0003;
        req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'hBBBB_0007;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_rdy0", 32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("t2_rdy1", 32'(req1_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            chk("t2_we",    32'(we),    32'd1);
            chk("t2_waddr", 32'(waddr), (i % 2 == 0) ? 32'd3 : 32'd7);
            chk("t2_wdata", wdata,      (i % 2 == 0) ? 32'hAAAA_0003 : 32'hBBBB_0007);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        chk("t2_we_off", 32'(we), 32'd0);

        // 3: reserve, stall, commit with same-cycle re-reservation
        rsv_valid = 1'b1; rsv_addr = 5'd9;
        #1;
        chk("t3_rsv_first", 32'(rsv_stall), 32'd0);
        tick();
        rsv_valid = 1'b0;
        q_addr1 = 5'd9; q_addr2 = 5'd9;
        #1;
        chk("t3_busy1", 32'(q_busy1), 32'd1);
        chk("t3_busy2", 32'(q_busy2), 32'd1);
        chk("t3_idle",  32'(idle),    32'd0);
        rsv_valid = 1'b1;
        #1;
        chk("t3_rsv_stall", 32'(rsv_stall), 32'd1);
        req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'hCAFE_0009;
        #1;
        chk("t3_rdy1",       32'(req1_ready), 32'd1);
        chk("t3_bypass",     32'(rsv_stall),  32'd0);
        chk("t3_no_q_bypass", 32'(q_busy1),   32'd1);
        tick();
        req1_valid = 1'b0; rsv_valid = 1'b0;
        chk("t3_we",       32'(we),      32'd1);
        chk("t3_waddr",    32'(waddr),   32'd9);
        chk("t3_wdata",    wdata,        32'hCAFE_0009);
        chk("t3_set_wins", 32'(q_busy1), 32'd1);
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h0000_0099;
        #1;
        chk("t3_rdy0", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        chk("t3_we2",    32'(we),      32'd1);
        chk("t3_cleared", 32'(q_busy1), 32'd0);
        tick();
        chk("t3_idle_end", 32'(idle), 32'd1);

        // 4: register 0
        req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'hFFFF_FFFF;
        rsv_valid  = 1'b1; rsv_addr  = 5'd0;
        q_addr1 = 5'd0;
        #1;
        chk("t4_rdy0",  32'(req0_ready), 32'd1);
        chk("t4_stall", 32'(rsv_stall),  32'd0);
        chk("t4_qbusy", 32'(q_busy1),    32'd0);
        tick();
        req0_valid = 1'b0; rsv_valid = 1'b0;
        chk("t4_we",      32'(we),      32'd0);
        chk("t4_qbusy2",  32'(q_busy1), 32'd0);
        chk("t4_idle",    32'(idle),    32'd1);

        // 5: reset during a grant with reservations outstanding
        rsv_valid = 1'b1; rsv_addr = 5'd4;
        tick();
        rsv_addr = 5'd6;
        tick();
        rsv_valid = 1'b0;
        q_addr1 = 5'd4; q_addr2 = 5'd6;
        #1;
        chk("t5_busy4", 32'(q_busy1), 32'd1);
        chk("t5_busy6", 32'(q_busy2), 32'd1);
        req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 32'hDEAD_BEEF;
        req1_valid = 1'b1; req1_addr = 5'd11; req1_data = 32'h1111_2222;
        #1;
        chk("t5_rdy0", 32'(req0_ready), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk("t5_we",     32'(we),      32'd0);
        chk("t5_busy4c", 32'(q_busy1), 32'd0);
        chk("t5_busy6c", 32'(q_busy2), 32'd0);
        chk("t5_idle",   32'(idle),    32'd1);
        // prio back at 0: requester 0 wins the first contention
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("t5_prio_rdy0", 32'(req0_ready), 32'd1);
        chk("t5_prio_rdy1", 32'(req1_ready), 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
